// File: rtl/vcache_line_fetch.sv
// Wishbone B3 classic read master that streams a framebuffer, one line per burst, into an FWFT pixel FIFO.
// Define VCACHE_TIMEOUT_EN to terminate a stalled strobe as a bus error after TIMEOUT cycles.
module vcache_line_fetch #(
  parameter logic [31:0] FB_BASE     = 32'h0000_0000,
  parameter int          LINE_WORDS  = 160,
  parameter int          NUM_LINES   = 120,
  parameter int          FIFO_DEPTH  = 256,
  parameter int          START_DELAY = 16,
  parameter int          TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        wb_ack_i,
  input  logic                        wb_err_i,
  input  logic                        wb_rty_i,
  input  logic [31:0]                 wb_dat_i,
  output logic                        wb_cyc_o,
  output logic [31:0]                 wb_adr_o,
  output logic                        wb_stb_o,
  output logic                        wb_we_o,
  output logic [3:0]                  wb_sel_o,
  output logic [31:0]                 wb_dat_o,
  input  logic                        frame_start_i,
  input  logic                        pix_rd_i,
  output logic [31:0]                 pix_dat_o,
  output logic                        pix_valid_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic                        err_o,
  output logic                        frame_done_o
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LVW     = AW + 1;
  localparam int WW      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int LNW     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int SD_LOAD = (START_DELAY > 0) ? START_DELAY - 1 : 0;
  localparam int SDW     = (SD_LOAD > 0) ? $clog2(SD_LOAD + 1) : 1;

  typedef enum logic [1:0] {ST_STARTUP, ST_LINE_WAIT, ST_BURST} state_t;

  state_t            state_q, state_d;
  logic [SDW-1:0]    dly_q, dly_d;
  logic [31:0]       adr_q, adr_d;
  logic [LNW-1:0]    line_q, line_d;
  logic [WW-1:0]     word_q, word_d;
  logic              cyc_q, cyc_d, stb_q, stb_d, err_q, err_d, done_q, done_d;
  logic [3:0]        sel_q, sel_d;

  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVW-1:0]    level_q, level_d;
  logic [31:0]       head_q, head_d;
  logic              valid_q, valid_d;

  logic              fifo_we, fifo_re, flush, advance, tmo_hit;
  logic [31:0]       fifo_wdat;
  logic [LVW-1:0]    free_c;

  assign free_c = LVW'(FIFO_DEPTH) - level_q;

`ifdef VCACHE_TIMEOUT_EN
  localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'((TIMEOUT > 1) ? TIMEOUT - 1 : 0);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          stall;

  // Down-counter reloads on any termination, new word or idle strobe.
  assign stall   = (state_q == ST_BURST) && stb_q && !wb_ack_i && !wb_err_i && !wb_rty_i;
  assign tmo_hit = stall && (tmo_q == '0);
  assign tmo_d   = (stall && !tmo_hit) ? tmo_q - TW'(1) : TMO_LOAD;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) tmo_q <= TMO_LOAD;
    else          tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    adr_d     = adr_q;
    line_d    = line_q;
    word_d    = word_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    sel_d     = sel_q;
    err_d     = err_q;
    done_d    = 1'b0;
    fifo_we   = 1'b0;
    fifo_wdat = 32'h0;
    flush     = 1'b0;
    advance   = 1'b0;

    case (state_q)
      ST_STARTUP: begin
        if (dly_q == '0) state_d = ST_LINE_WAIT;
        else             dly_d   = dly_q - SDW'(1);
      end
      ST_LINE_WAIT: begin
        if (free_c >= LVW'(LINE_WORDS)) begin
          state_d = ST_BURST;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          sel_d   = 4'hF;
        end
      end
      ST_BURST: begin
        if (!stb_q) begin
          stb_d = 1'b1;
        end else if (wb_err_i || tmo_hit) begin
          fifo_we = 1'b1;
          err_d   = 1'b1;
          advance = 1'b1;
        end else if (wb_rty_i) begin
          stb_d = 1'b0;
        end else if (wb_ack_i) begin
          fifo_we   = 1'b1;
          fifo_wdat = wb_dat_i;
          advance   = 1'b1;
        end
      end
      default: state_d = ST_STARTUP;
    endcase

    if (advance) begin
      adr_d = adr_q + 32'd4;
      if (word_q == WW'(LINE_WORDS - 1)) begin
        word_d  = '0;
        state_d = ST_LINE_WAIT;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        sel_d   = 4'h0;
        if (line_q == LNW'(NUM_LINES - 1)) begin
          line_d = '0;
          adr_d  = FB_BASE;
          done_d = 1'b1;
        end else begin
          line_d = line_q + LNW'(1);
        end
      end else begin
        word_d = word_q + WW'(1);
      end
    end

    // Resync overrides any termination seen in the same cycle; err_o survives it.
    if (frame_start_i && (state_q != ST_STARTUP)) begin
      flush   = 1'b1;
      fifo_we = 1'b0;
      state_d = ST_LINE_WAIT;
      adr_d   = FB_BASE;
      line_d  = '0;
      word_d  = '0;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      sel_d   = 4'h0;
      done_d  = 1'b0;
      err_d   = err_q;
    end
  end

  always_comb begin
    fifo_re  = pix_rd_i && valid_q;
    wr_ptr_d = wr_ptr_q + (fifo_we ? AW'(1) : AW'(0));
    rd_ptr_d = rd_ptr_q + (fifo_re ? AW'(1) : AW'(0));
    level_d  = level_q + LVW'(fifo_we) - LVW'(fifo_re);
    // Registered head: a write lands at the head only when it becomes the sole entry.
    head_d   = (fifo_we && (wr_ptr_q == rd_ptr_d)) ? fifo_wdat : mem_q[rd_ptr_d];
    valid_d  = (level_d != '0);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      head_d   = 32'h0;
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (fifo_we) mem_q[wr_ptr_q] <= fifo_wdat;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_STARTUP;
      dly_q    <= SDW'(SD_LOAD);
      adr_q    <= FB_BASE;
      line_q   <= '0;
      word_q   <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      sel_q    <= 4'h0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= 32'h0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      adr_q    <= adr_d;
      line_q   <= line_d;
      word_q   <= word_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = stb_q;
  assign wb_adr_o     = adr_q;
  assign wb_sel_o     = sel_q;
  assign wb_we_o      = 1'b0;
  assign wb_dat_o     = 32'h0;
  assign pix_dat_o    = head_q;
  assign pix_valid_o  = valid_q;
  assign fifo_level_o = level_q;
  assign err_o        = err_q;
  assign frame_done_o = done_q;

endmodule
